video_frame_buffer: RTL and testbench



---
 rtl/video_pkg.sv | 25 ++
 rtl/fb_addr_gen.sv | 22 ++
 rtl/video_frame_buffer.sv | 170 +++++++++++++++++
 tb/tb_video_frame_buffer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared types and helpers for the video frame buffer.
package video_pkg;

   localparam int unsigned H_RES_DEF   = 640;
   localparam int unsigned V_RES_DEF   = 480;
   localparam int unsigned PIXEL_W_DEF = 16;

   typedef logic [PIXEL_W_DEF-1:0] pixel_t;

   // Bank swap handshake: FILL while the writer owns the back bank,
   // PENDING once a finished frame waits for the display frame boundary.
   typedef enum logic {
      FILL    = 1'b0,
      PENDING = 1'b1
   } swap_state_t;

   // Linear pixel address width for one frame (never below one bit).
   function automatic int unsigned addr_w(input int unsigned h_res,
                                          input int unsigned v_res);
      int unsigned w;
      w = $clog2(h_res * v_res);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Raster coordinate to linear frame address, with bounds check.
module fb_addr_gen
   import video_pkg::*;
#(
   parameter int unsigned H_RES  = H_RES_DEF,
   parameter int unsigned V_RES  = V_RES_DEF,
   parameter int unsigned CNT_W  = 10,
   parameter int unsigned ADDR_W = addr_w(H_RES, V_RES)
) (
   input  logic [CNT_W-1:0]  hcount,
   input  logic [CNT_W-1:0]  vcount,
   output logic [ADDR_W-1:0] addr,
   output logic              in_range
);

   // addr = vcount*H_RES + hcount; only meaningful when in_range is set
   always_comb begin
      in_range = (32'(hcount) < H_RES) && (32'(vcount) < V_RES);
      addr     = ADDR_W'(32'(vcount) * H_RES + 32'(hcount));
   end

endmodule

// File: rtl/video_frame_buffer.sv
// Camera-to-display frame buffer: inferred dual-port RAM, two-cycle
// registered read, optional ping-pong banks with tear-free swap.
// Define VIDEO_FB_DOUBLE_BUFFER_EN for two banks; otherwise a single
// shared read-first bank is built and the frame handshake is ignored.
module video_frame_buffer
   import video_pkg::*;
#(
   parameter int unsigned       H_RES       = H_RES_DEF,
   parameter int unsigned       V_RES       = V_RES_DEF,
   parameter int unsigned       PIXEL_W     = PIXEL_W_DEF,
   parameter int unsigned       CNT_W       = 10,
   parameter logic [PIXEL_W-1:0] BLANK_VALUE = '0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               wr_en,
   input  logic [CNT_W-1:0]   wr_hcount,
   input  logic [CNT_W-1:0]   wr_vcount,
   input  logic [PIXEL_W-1:0] wr_data,
   input  logic               wr_frame_end,
   input  logic               rd_en,
   input  logic [CNT_W-1:0]   rd_hcount,
   input  logic [CNT_W-1:0]   rd_vcount,
   input  logic               rd_frame_start,
   output logic [PIXEL_W-1:0] rd_data,
   output logic               rd_valid,
   output logic               front_bank,
   output logic               frame_swapped,
   output logic               overrun,
   output logic [15:0]        wr_drop_count
);

   localparam int unsigned ADDR_W   = addr_w(H_RES, V_RES);
   localparam int unsigned DEPTH    = H_RES * V_RES;
   localparam logic [15:0] DROP_MAX = 16'hFFFF;

   logic [ADDR_W-1:0]  wr_addr;
   logic [ADDR_W-1:0]  rd_addr;
   logic               wr_in_range;
   logic               rd_in_range;
   logic               wr_accept_c;
   logic               rd_lookup_c;
   logic [PIXEL_W-1:0] ram_q;
   logic               rd_en_q;
   logic               rd_in_range_q;

   fb_addr_gen #(
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .CNT_W  (CNT_W),
      .ADDR_W (ADDR_W)
   ) u_wr_addr (
      .hcount   (wr_hcount),
      .vcount   (wr_vcount),
      .addr     (wr_addr),
      .in_range (wr_in_range)
   );

   fb_addr_gen #(
      .H_RES  (H_RES),
      .V_RES  (V_RES),
      .CNT_W  (CNT_W),
      .ADDR_W (ADDR_W)
   ) u_rd_addr (
      .hcount   (rd_hcount),
      .vcount   (rd_vcount),
      .addr     (rd_addr),
      .in_range (rd_in_range)
   );

   assign wr_accept_c = wr_en & wr_in_range;
   // Out-of-range reads never touch the RAM
   assign rd_lookup_c = rd_en & rd_in_range;

`ifdef VIDEO_FB_DOUBLE_BUFFER_EN

   logic [PIXEL_W-1:0] mem [2][DEPTH];
   swap_state_t        state;

   // Writer fills the back bank; reader samples the front bank (read-first)
   always_ff @(posedge clk) begin
      if (wr_accept_c) begin
         mem[~front_bank][wr_addr] <= wr_data;
      end
      if (rd_lookup_c) begin
         ram_q <= mem[front_bank][rd_addr];
      end
   end

   // Bank swap handshake; swaps only on a display frame start
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= FILL;
         front_bank    <= 1'b0;
         frame_swapped <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         frame_swapped <= 1'b0;
         overrun       <= 1'b0;
         case (state)
            FILL: begin
               if (wr_frame_end && rd_frame_start) begin
                  front_bank    <= ~front_bank;
                  frame_swapped <= 1'b1;
               end else if (wr_frame_end) begin
                  state <= PENDING;
               end
            end
            PENDING: begin
               if (rd_frame_start) begin
                  front_bank    <= ~front_bank;
                  frame_swapped <= 1'b1;
                  state         <= FILL;
               end else if (wr_frame_end) begin
                  overrun <= 1'b1;
               end
            end
         endcase
      end
   end

`else

   logic [PIXEL_W-1:0] mem [DEPTH];
   logic               unused_frame_pulses;

   // Single shared bank, read-first on address collision
   always_ff @(posedge clk) begin
      if (wr_accept_c) begin
         mem[wr_addr] <= wr_data;
      end
      if (rd_lookup_c) begin
         ram_q <= mem[rd_addr];
      end
   end

   assign front_bank          = 1'b0;
   assign frame_swapped       = 1'b0;
   assign overrun             = 1'b0;
   assign unused_frame_pulses = wr_frame_end ^ rd_frame_start;

`endif

   // Second read stage: present RAM word or blank, with valid
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rd_en_q       <= 1'b0;
         rd_in_range_q <= 1'b0;
         rd_valid      <= 1'b0;
         rd_data       <= '0;
      end else begin
         rd_en_q       <= rd_en;
         rd_in_range_q <= rd_in_range;
         rd_valid      <= rd_en_q;
         if (rd_en_q) begin
            rd_data <= rd_in_range_q ? ram_q : BLANK_VALUE;
         end
      end
   end

   // Saturating count of out-of-range write strobes
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_drop_count <= '0;
      end else if (wr_en && !wr_in_range && (wr_drop_count != DROP_MAX)) begin
         wr_drop_count <= wr_drop_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_video_frame_buffer.sv
// Self-checking bench for video_frame_buffer (both buffer modes).
module tb_video_frame_buffer;
   import video_pkg::*;

   localparam int unsigned H    = 640;
   localparam int unsigned V    = 8;
   localparam int unsigned NPIX = H * V;
   localparam logic [15:0] BLANK = 16'hDEAD;
`ifdef VIDEO_FB_DOUBLE_BUFFER_EN
   localparam bit DBL = 1'b1;
`else
   localparam bit DBL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        wr_en;
   logic [9:0]  wr_hcount;
   logic [9:0]  wr_vcount;
   logic [15:0] wr_data;
   logic        wr_frame_end;
   logic        rd_en;
   logic [9:0]  rd_hcount;
   logic [9:0]  rd_vcount;
   logic        rd_frame_start;
   logic [15:0] rd_data;
   logic        rd_valid;
   logic        front_bank;
   logic        frame_swapped;
   logic        overrun;
   logic [15:0] wr_drop_count;

   always #5 clk = ~clk;

   video_frame_buffer #(
      .H_RES       (H),
      .V_RES       (V),
      .PIXEL_W     (16),
      .CNT_W       (10),
      .BLANK_VALUE (BLANK)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .wr_en          (wr_en),
      .wr_hcount      (wr_hcount),
      .wr_vcount      (wr_vcount),
      .wr_data        (wr_data),
      .wr_frame_end   (wr_frame_end),
      .rd_en          (rd_en),
      .rd_hcount      (rd_hcount),
      .rd_vcount      (rd_vcount),
      .rd_frame_start (rd_frame_start),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .front_bank     (front_bank),
      .frame_swapped  (frame_swapped),
      .overrun        (overrun),
      .wr_drop_count  (wr_drop_count)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: frame storage per bank plus what the display should see
   pixel_t m_mem   [2][NPIX];
   bit     m_known [2][NPIX];
   int     m_front;
   bit     m_pending;
   int     m_drops;
   bit     m_swapped;
   bit     m_overrun;
   bit     pend_valid;
   bit     pend_known;
   pixel_t pend_data;
   bit     m_rd_valid;
   bit     m_rd_known;
   pixel_t m_rd_data;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Apply the design rules for one rising edge using the inputs now applied
   task automatic model_edge();
      int a;
      int b;
      if (!reset_n) begin
         m_front    = 0;
         m_pending  = 1'b0;
         m_drops    = 0;
         m_swapped  = 1'b0;
         m_overrun  = 1'b0;
         pend_valid = 1'b0;
         m_rd_valid = 1'b0;
         m_rd_data  = '0;
         m_rd_known = 1'b1;
         return;
      end
      // a request looked up one edge ago becomes visible now
      m_rd_valid = pend_valid;
      if (pend_valid) begin
         m_rd_data  = pend_data;
         m_rd_known = pend_known;
      end
      // this edge's lookup sees memory before this edge's write
      pend_valid = rd_en;
      if (rd_en) begin
         if (rd_hcount < H && rd_vcount < V) begin
            a          = int'(rd_vcount) * H + int'(rd_hcount);
            b          = DBL ? m_front : 0;
            pend_data  = m_mem[b][a];
            pend_known = m_known[b][a];
         end else begin
            pend_data  = BLANK;
            pend_known = 1'b1;
         end
      end
      if (wr_en) begin
         if (wr_hcount < H && wr_vcount < V) begin
            a = int'(wr_vcount) * H + int'(wr_hcount);
            b = DBL ? 1 - m_front : 0;
            m_mem[b][a]   = wr_data;
            m_known[b][a] = 1'b1;
         end else if (m_drops < 65535) begin
            m_drops++;
         end
      end
      m_swapped = 1'b0;
      m_overrun = 1'b0;
      if (DBL) begin
         if (rd_frame_start && (m_pending || wr_frame_end)) begin
            m_front   = 1 - m_front;
            m_swapped = 1'b1;
            m_pending = 1'b0;
         end else if (wr_frame_end) begin
            if (m_pending) m_overrun = 1'b1;
            m_pending = 1'b1;
         end
      end
   endtask

   // One clock: model update at the edge, compare all outputs 1ns later
   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      check("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
      if (m_rd_known) check("rd_data", 32'(rd_data), 32'(m_rd_data));
      check("front_bank", 32'(front_bank), 32'(m_front));
      check("frame_swapped", 32'(frame_swapped), 32'(m_swapped));
      check("overrun", 32'(overrun), 32'(m_overrun));
      check("wr_drop_count", 32'(wr_drop_count), 32'(m_drops));
   endtask

   task automatic idle();
      wr_en = 1'b0; wr_hcount = '0; wr_vcount = '0; wr_data = '0; wr_frame_end = 1'b0;
      rd_en = 1'b0; rd_hcount = '0; rd_vcount = '0; rd_frame_start = 1'b0;
   endtask

   task automatic rand_read();
      rd_en     = ($urandom_range(0, 1) == 1);
      rd_hcount = 10'($urandom_range(0, H + 3));
      rd_vcount = 10'($urandom_range(0, V + 1));
   endtask

   // Single isolated read: nothing after one edge, pixel after two
   task automatic read_px(input int h, input int v, input logic [15:0] exp, input string tag);
      idle(); cycle();
      rd_en = 1'b1; rd_hcount = 10'(h); rd_vcount = 10'(v);
      cycle();
      idle();
      check({tag, "_lat1_valid"}, 32'(rd_valid), 32'd0);
      cycle();
      check({tag, "_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_data"}, 32'(rd_data), 32'(exp));
   endtask

   initial begin
      idle();
      reset_n = 1'b0;
      cycle(); cycle();
      check("rst_rd_data", 32'(rd_data), 32'd0);
      check("rst_rd_valid", 32'(rd_valid), 32'd0);
      check("rst_front", 32'(front_bank), 32'd0);
      check("rst_drops", 32'(wr_drop_count), 32'd0);
      reset_n = 1'b1;

      // pixel (5,3)
      wr_en = 1'b1; wr_hcount = 10'd5; wr_vcount = 10'd3; wr_data = 16'hABCD;
      #1;
      check("addr_5_3", 32'(dut.u_wr_addr.addr), 32'(3 * H + 5));
      cycle();
      idle();
      wr_frame_end = 1'b1; cycle(); idle();
`ifdef VIDEO_FB_DOUBLE_BUFFER_EN
      check("pending_front", 32'(front_bank), 32'd0);
`endif
      rd_frame_start = 1'b1; cycle(); idle();
`ifdef VIDEO_FB_DOUBLE_BUFFER_EN
      check("swap_pulse", 32'(frame_swapped), 32'd1);
      check("swap_front", 32'(front_bank), 32'd1);
`else
      check("no_swap_pulse", 32'(frame_swapped), 32'd0);
`endif
      cycle();
      check("swap_pulse_one_cycle", 32'(frame_swapped), 32'd0);
      read_px(5, 3, 16'hABCD, "rd_5_3");

      // out-of-range write and read
      wr_en = 1'b1; wr_hcount = 10'(H); wr_vcount = 10'd0; wr_data = 16'h5555;
      cycle(); idle();
      check("drop_one", 32'(wr_drop_count), 32'd1);
      read_px(0, V, BLANK, "rd_oob");

      // fill a whole frame with 0x1111 while the display reads randomly
      for (int v = 0; v < V; v++) begin
         for (int h = 0; h < H; h++) begin
            wr_en = 1'b1; wr_hcount = 10'(h); wr_vcount = 10'(v); wr_data = 16'h1111;
            rand_read();
            cycle();
         end
      end
      idle();
      wr_frame_end = 1'b1; cycle(); idle();
      rd_frame_start = 1'b1; cycle(); idle();
`ifdef VIDEO_FB_DOUBLE_BUFFER_EN
      check("fill_swap_front", 32'(front_bank), 32'd0);
`endif
      for (int i = 0; i < 200; i++) begin
         rand_read();
         cycle();
      end
      read_px(7, 2, 16'h1111, "rd_fill");

      // collision: write (0,0)=7 while reading (0,0) in the same cycle
      idle(); cycle();
      wr_en = 1'b1; wr_data = 16'd7; rd_en = 1'b1;
      cycle(); idle(); cycle();
      check("collide_old", 32'(rd_data), 32'h1111);
`ifdef VIDEO_FB_DOUBLE_BUFFER_EN
      read_px(0, 0, 16'h1111, "rd_after_collide");
`else
      read_px(0, 0, 16'd7, "rd_after_collide");
`endif

      // overrun and simultaneous handshake
      wr_frame_end = 1'b1; cycle(); idle();
      wr_frame_end = 1'b1; cycle(); idle();
`ifdef VIDEO_FB_DOUBLE_BUFFER_EN
      check("overrun_pulse", 32'(overrun), 32'd1);
      check("overrun_front", 32'(front_bank), 32'd0);
`else
      check("no_overrun", 32'(overrun), 32'd0);
`endif
      rd_frame_start = 1'b1; cycle(); idle();
      wr_frame_end = 1'b1; rd_frame_start = 1'b1; cycle(); idle();
`ifdef VIDEO_FB_DOUBLE_BUFFER_EN
      check("both_swap", 32'(frame_swapped), 32'd1);
`endif
      cycle();

      // random traffic including collisions and frame pulses
      for (int i = 0; i < 2500; i++) begin
         wr_en     = ($urandom_range(0, 3) != 0);
         wr_hcount = 10'($urandom_range(0, H + 3));
         wr_vcount = 10'($urandom_range(0, V + 1));
         wr_data   = 16'($urandom);
         rand_read();
         if ($urandom_range(0, 7) == 0) begin
            rd_hcount = wr_hcount; rd_vcount = wr_vcount; rd_en = 1'b1;
         end
         wr_frame_end   = ($urandom_range(0, 150) == 0);
         rd_frame_start = ($urandom_range(0, 150) == 0);
         cycle();
      end
      idle();

      // reset during a read burst
      for (int i = 0; i < 5; i++) begin
         rd_en = 1'b1; rd_hcount = 10'($urandom_range(0, H - 1)); rd_vcount = 10'($urandom_range(0, V - 1));
         cycle();
      end
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
      check("midrst_valid", 32'(rd_valid), 32'd0);
      check("midrst_front", 32'(front_bank), 32'd0);
      check("midrst_drops", 32'(wr_drop_count), 32'd0);
`ifdef VIDEO_FB_DOUBLE_BUFFER_EN
      check("midrst_state", 32'(dut.state), 32'(FILL));
`endif
      for (int i = 0; i < 6; i++) begin
         rand_read();
         cycle();
      end
      idle(); cycle(); cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
